// File: rtl/reset_sequencer.sv
// reset_sequencer: brings up the ZBT RAM interface first and the core logic
// second, once the DCM lock has been stable for long enough. Any loss of lock
// sends both blocks back into reset and restarts the sequence. Lock drops are
// counted, saturating, so they can be shown on the hex display or LEDs.
//
// Handshake: there is none. Every output is registered and valid on every
// cycle after the first rising edge with reset_n low.
module reset_sequencer #(
   parameter int LOCK_CYCLES  = 1024,
   parameter int STAGE_CYCLES = 16,
   parameter int CNT_W        = 16
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       locked_in,
   output logic       ram_reset,
   output logic       core_reset,
   output logic       ready,
   output logic [7:0] lock_loss_count,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      STABILIZE = 2'd1,
      RAM_UP    = 2'd2,
      RUN       = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_CYCLES - 1);
   localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_CYCLES - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sync1, locked_sync;
   logic             loss;

   // Two-flop synchronizer for the asynchronous DCM lock; no glitch filter.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         sync1       <= 1'b0;
         locked_sync <= 1'b0;
      end else begin
         sync1       <= locked_in;
         locked_sync <= sync1;
      end
   end

   // Next-state and counter logic; a lock loss wins over count completion.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      loss    = 1'b0;
      case (state_q)
         WAIT_LOCK: begin
            cnt_d = '0;
            if (locked_sync) state_d = STABILIZE;
         end
         STABILIZE: begin
            if (!locked_sync) begin
               state_d = WAIT_LOCK;
               cnt_d   = '0;
               loss    = 1'b1;
            end else if (cnt_q == LOCK_LAST) begin
               state_d = RAM_UP;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RAM_UP: begin
            if (!locked_sync) begin
               state_d = WAIT_LOCK;
               cnt_d   = '0;
               loss    = 1'b1;
            end else if (cnt_q == STAGE_LAST) begin
               state_d = RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RUN: begin
            cnt_d = '0;
            if (!locked_sync) begin
               state_d = WAIT_LOCK;
               loss    = 1'b1;
            end
         end
         default: begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
         end
      endcase
   end

   // State, counter, loss counter and outputs decoded from the next state,
   // so the resets move on the same edge as the state.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q         <= WAIT_LOCK;
         cnt_q           <= '0;
         lock_loss_count <= 8'd0;
         ram_reset       <= 1'b1;
         core_reset      <= 1'b1;
         ready           <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ram_reset  <= !((state_d == RAM_UP) || (state_d == RUN));
         core_reset <= (state_d != RUN);
         ready      <= (state_d == RUN);
         if (loss && (lock_loss_count != 8'hFF))
            lock_loss_count <= lock_loss_count + 8'd1;
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: randomized and directed lock patterns; a reference model
// predicts the outputs after every edge from the length of the current
// unbroken run of synchronized lock, and a monitor compares them.
module tb_reset_sequencer;

   localparam int L = 8;
   localparam int S = 4;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       locked_in;
   logic       ram_reset, core_reset, ready;
   logic [7:0] lock_loss_count;
   logic [1:0] state;

   int errors = 0;
   int checks = 0;
   int cycle  = 0;

   logic [12:0] exp_q[$];

   reset_sequencer #(.LOCK_CYCLES(L), .STAGE_CYCLES(S), .CNT_W(16)) dut (
      .clock(clock),
      .reset_n(reset_n),
      .locked_in(locked_in),
      .ram_reset(ram_reset),
      .core_reset(core_reset),
      .ready(ready),
      .lock_loss_count(lock_loss_count),
      .state(state)
   );

   // Clock
   always #5 clock = ~clock;

   // Reference model: run = edges in a row with synchronized lock high.
   // 0 -> WAIT_LOCK, 1..L -> STABILIZE, L+1..L+S -> RAM_UP, beyond -> RUN.
   logic m_s1 = 1'b0, m_s2 = 1'b0;
   int   m_run = 0;
   int   m_cnt = 0;
   always @(posedge clock) begin
      logic       ls;
      logic [1:0] st;
      cycle = cycle + 1;
      if (!reset_n) begin
         m_s1 = 1'b0; m_s2 = 1'b0; m_run = 0; m_cnt = 0;
      end else begin
         ls   = m_s2;
         m_s2 = m_s1;
         m_s1 = locked_in;
         if (ls) begin
            if (m_run <= L + S) m_run = m_run + 1;
         end else begin
            if (m_run > 0 && m_cnt < 255) m_cnt = m_cnt + 1;
            m_run = 0;
         end
      end
      if (m_run == 0)          st = 2'd0;
      else if (m_run <= L)     st = 2'd1;
      else if (m_run <= L + S) st = 2'd2;
      else                     st = 2'd3;
      exp_q.push_back({st, (st < 2'd2), (st != 2'd3), (st == 2'd3), 8'(m_cnt)});
   end

   // Monitor: outputs are valid every cycle; compare on the falling edge.
   always @(negedge clock) begin
      logic [12:0] e;
      logic [12:0] got;
      got = {state, ram_reset, core_reset, ready, lock_loss_count};
      checks = checks + 1;
      if (exp_q.size() == 0) begin
         errors = errors + 1;
         $display("FAIL scoreboard_empty cycle=%0d got=%h", cycle, got);
      end else begin
         e = exp_q.pop_front();
         if (got !== e) begin
            errors = errors + 1;
            $display("FAIL outputs cycle=%0d got state=%0d ram=%b core=%b ready=%b cnt=%0d exp state=%0d ram=%b core=%b ready=%b cnt=%0d",
                     cycle, state, ram_reset, core_reset, ready, lock_loss_count,
                     e[12:11], e[10], e[9], e[8], e[7:0]);
         end
      end
   end

   // Driver tasks: inputs change on the falling edge.
   task automatic hold(input logic lock, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         locked_in = lock;
      end
   endtask

   task automatic do_reset(input int n);
      @(negedge clock);
      reset_n = 1'b0;
      for (int i = 1; i < n; i++) @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n   = 1'b0;
      locked_in = 1'b1;
      // Reset with lock already high, then normal bring-up into RUN.
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      hold(1'b1, 20);
      // Single-cycle loss in RUN and full re-sequence.
      hold(1'b0, 1);
      hold(1'b1, 20);
      // One-cycle drops at every point of STABILIZE and RAM_UP.
      for (int d = 1; d <= 16; d++) begin
         hold(1'b0, 3);
         hold(1'b1, d);
         hold(1'b0, 1);
      end
      hold(1'b1, 20);
      // Saturation: well over 255 drops.
      for (int i = 0; i < 270; i++) begin
         hold(1'b1, 1);
         hold(1'b0, 1);
      end
      hold(1'b1, 20);
      hold(1'b0, 2);
      hold(1'b1, 20);
      // reset_n in RUN with a non-zero loss count.
      do_reset(2);
      hold(1'b1, 20);
      for (int i = 0; i < 3; i++) begin
         hold(1'b0, 2);
         hold(1'b1, 20);
      end
      do_reset(1);
      hold(1'b1, 20);
      // Random lock patterns with occasional resets.
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 19))
            0:       do_reset($urandom_range(1, 3));
            1, 2, 3: hold(1'b0, $urandom_range(1, 3));
            default: hold(1'b1, $urandom_range(1, 20));
         endcase
      end
      @(negedge clock);
      #1;
      checks = checks + 1;
      if (exp_q.size() > 1) begin
         errors = errors + 1;
         $display("FAIL leftover_expected got=%0d required<=1", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
